keep_one_in_n_unzip: RTL and testbench
======================================

Name: keep_one_in_n_unzip

Overview:
- Receive-side inverse of the sample zip stage in the QPSK RFNoC chain.
- Accepts one packed 32-bit AXI-Stream word holding four 8-bit symbols. Each symbol is 4-bit I in bits [7:4] and 4-bit Q in bits [3:0].
- Emits four 32-bit samples per input word, each with 16-bit I in [31:16] and 16-bit Q in [15:0].
- Sits between the packed-data transport and the 16-bit IQ processing blocks. The rate is 1 input word to 4 output samples.

Parameters:
- WIDTH, 32, stream data width. Only 32 is supported; any other value is an elaboration error.

Ports:
- clk  input  1  clock
- reset  input  1  asynchronous, active-high reset
- i_tdata  input  WIDTH  packed word, four symbols
- i_tlast  input  1  end of packet on the packed stream
- i_tvalid  input  1  input valid
- i_tready  output  1  input ready
- o_tdata  output  WIDTH  expanded sample {I16, Q16}
- o_tlast  output  1  end of packet on the expanded stream
- o_tvalid  output  1  output valid
- o_tready  input  1  output ready

Behaviour:
- State:
  - full: 1-bit, hold register occupied.
  - lane: 2-bit counter, 0..3.
  - hold: WIDTH-bit captured word.
  - hold_last: 1-bit captured i_tlast.
- Reset (asynchronous; takes effect immediately, including mid-word): full=0, lane=0, hold=0, hold_last=0. Outputs: o_tvalid=0, o_tlast=0, o_tdata=0, i_tready=1. A partially emitted word is discarded.
- FSM EMPTY (full=0):
  - i_tready=1, o_tvalid=0.
  - On i_tvalid: capture hold<=i_tdata, hold_last<=i_tlast, lane<=0, go to LOADED.
- FSM LOADED (full=1):
  - o_tvalid=1.
  - Output handshake is o_tvalid & o_tready.
  - On handshake with lane<3: lane<=lane+1.
  - On handshake with lane==3: if i_tvalid, capture the next word and stay LOADED with lane<=0; otherwise go to EMPTY.
- i_tready = ~full | (lane==3 & o_tready). This gives back-to-back words with no bubble.
- Lane-to-byte order (fixed, matches the zip packer):
  - lane0 = hold[31:24]
  - lane1 = hold[7:0]
  - lane2 = hold[15:8]
  - lane3 = hold[23:16]
- Expansion of byte b:
  - I16 = {b[7:4], 12'h000}
  - Q16 = {b[3:0], 12'h000}
  - The nibble lands in the MSBs, so two's-complement sign is preserved. No arithmetic beyond bit placement.
- o_tdata = full ? {I16, Q16} of the current lane : 0. It is driven from registers only; there is no combinational path from i_tdata.
- o_tlast = full & hold_last & (lane==3). It is asserted on the 4th sample only.
- Latency: a word accepted on edge N gives its lane0 output valid in the cycle after N. At full throughput a new word is accepted every 4 output beats.
- Backpressure:
  - o_tdata and o_tlast hold stable while o_tvalid & ~o_tready.
  - lane does not advance without a handshake.
- Simultaneous final handshake and new input: both occur on the same edge; lane wraps to 0 and hold is replaced.
- i_tvalid while full and lane<3: ignored (i_tready=0). Upstream must hold the word per AXI-S.

Optional Feature:
- Macro: UNZIP_MIDRISE_EN.
- Defined: the 12 fill bits are 12'h800 instead of 12'h000, giving mid-rise reconstruction. I16={b[7:4],12'h800}, Q16={b[3:0],12'h800}. With full=0, o_tdata is still 0.
- Undefined: zero fill as specified in Behaviour.
- Handshake, latency and tlast behaviour are identical in both builds.

Test Plan:
- Single word: i_tdata=0xA1B2C3D4, i_tlast=0, o_tready=1. Required o_tdata sequence: 0xA0001000, 0xD0004000, 0xC0003000, 0xB0002000. o_tlast=0 throughout; return to EMPTY.
- Same word with UNZIP_MIDRISE_EN: required sequence 0xA8001800, 0xD8004800, 0xC8003800, 0xB8002800.
- Streaming: 3 words, i_tvalid held high, o_tready=1, last word with i_tlast=1.
  - Required: 12 consecutive o_tvalid beats with no gap.
  - i_tready high only on lane3 beats.
  - o_tlast only on beat 12.
- Backpressure: o_tready toggles 1,0,0,1,... on word 0x12345678. Required: outputs 0x10002000, 0x70008000, 0x50006000, 0x30004000 in order, each held stable while stalled, no duplicates or drops.
- Reset mid-word: assert reset after lane1 handshake. Required: o_tvalid=0, o_tdata=0 immediately, without waiting for a clock edge. After release, a fresh word 0xFFFFFFFF emits 0xF000F000 four times starting from lane0.
- Empty idle: i_tvalid=0 for 20 cycles. Required: o_tvalid=0, o_tdata=0, i_tready=1 constant.

Source files
------------

// File: rtl/keep_one_in_n_unzip.sv
// Unpacks one 32-bit word of four 4-bit IQ symbols into four {I16, Q16} samples.
// Build option: define UNZIP_MIDRISE_EN to fill the low 12 bits with 12'h800 instead of zero.
`timescale 1ns/1ps

module keep_one_in_n_unzip #(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [WIDTH-1:0] i_tdata,
   input  logic             i_tlast,
   input  logic             i_tvalid,
   output logic             i_tready,
   output logic [WIDTH-1:0] o_tdata,
   output logic             o_tlast,
   output logic             o_tvalid,
   input  logic             o_tready
);

   generate
      if (WIDTH != 32) begin : g_width_check
         $error("keep_one_in_n_unzip: only WIDTH = 32 is supported");
      end
   endgenerate

`ifdef UNZIP_MIDRISE_EN
   localparam logic [11:0] FILL = 12'h800;
`else
   localparam logic [11:0] FILL = 12'h000;
`endif

   // Both streams are AXI-Stream: a beat transfers on a rising edge where valid and
   // ready are both high; valid and its payload never drop until that beat transfers.

   typedef enum logic {
      ST_EMPTY  = 1'b0,
      ST_LOADED = 1'b1
   } state_t;

   state_t           state, state_d;
   logic [1:0]       lane, lane_d;
   logic [WIDTH-1:0] hold, hold_d;
   logic             hold_last, hold_last_d;
   logic             full;
   logic [7:0]       sel_byte;

   assign full = (state == ST_LOADED);

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state     <= ST_EMPTY;
         lane      <= 2'd0;
         hold      <= '0;
         hold_last <= 1'b0;
      end else begin
         state     <= state_d;
         lane      <= lane_d;
         hold      <= hold_d;
         hold_last <= hold_last_d;
      end
   end

   // In LOADED, the lane-3 beat may retire the word and capture the next on the same edge.
   always_comb begin
      state_d     = state;
      lane_d      = lane;
      hold_d      = hold;
      hold_last_d = hold_last;
      unique case (state)
         ST_EMPTY: begin
            if (i_tvalid) begin
               state_d     = ST_LOADED;
               lane_d      = 2'd0;
               hold_d      = i_tdata;
               hold_last_d = i_tlast;
            end
         end
         ST_LOADED: begin
            if (o_tready) begin
               if (lane != 2'd3) begin
                  lane_d = lane + 2'd1;
               end else if (i_tvalid) begin
                  lane_d      = 2'd0;
                  hold_d      = i_tdata;
                  hold_last_d = i_tlast;
               end else begin
                  state_d = ST_EMPTY;
                  lane_d  = 2'd0;
               end
            end
         end
         default: begin
            state_d = ST_EMPTY;
            lane_d  = 2'd0;
         end
      endcase
   end

   // Lane order matches the zip packer: top byte first, then the bytes from the bottom up.
   always_comb begin
      sel_byte = 8'h00;
      unique case (lane)
         2'd0:    sel_byte = hold[31:24];
         2'd1:    sel_byte = hold[7:0];
         2'd2:    sel_byte = hold[15:8];
         default: sel_byte = hold[23:16];
      endcase

      i_tready = ~full | ((lane == 2'd3) & o_tready);
      o_tvalid = full;
      o_tlast  = full & hold_last & (lane == 2'd3);
      o_tdata  = '0;
      if (full) begin
         o_tdata = {sel_byte[7:4], FILL, sel_byte[3:0], FILL};
      end
   end

endmodule

// File: tb/tb_keep_one_in_n_unzip.sv
// Bench for keep_one_in_n_unzip: directed test-plan steps plus random traffic
// scored against a byte-order model and an occupancy-based handshake model.
`timescale 1ns/1ps

module tb_keep_one_in_n_unzip;

   localparam int W = 33;

   logic        clk = 1'b0;
   logic        reset;
   logic [31:0] i_tdata;
   logic        i_tlast;
   logic        i_tvalid;
   logic        i_tready;
   logic [31:0] o_tdata;
   logic        o_tlast;
   logic        o_tvalid;
   logic        o_tready;

   int n_cmp = 0;
   int n_fail = 0;
   int cyc = 0;
   int rdy_mode = 0;
   int pat = 0;

   logic [W-1:0] exp_q[$];
   logic [31:0]  obs_log[$];
   logic         obs_last[$];
   int           beat_cyc[$];

`ifdef UNZIP_MIDRISE_EN
   localparam logic [11:0] FILL = 12'h800;
`else
   localparam logic [11:0] FILL = 12'h000;
`endif

   keep_one_in_n_unzip #(.WIDTH(32)) dut (
      .clk      (clk),
      .reset    (reset),
      .i_tdata  (i_tdata),
      .i_tlast  (i_tlast),
      .i_tvalid (i_tvalid),
      .i_tready (i_tready),
      .o_tdata  (o_tdata),
      .o_tlast  (o_tlast),
      .o_tvalid (o_tvalid),
      .o_tready (o_tready)
   );

   // clock / reset
   initial begin
      forever #5 clk = ~clk;
   end

   task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // reference model: a word becomes four samples, byte order 3,0,1,2, last on the 4th
   function automatic logic [31:0] expand(input logic [7:0] b);
      return {b[7:4], FILL, b[3:0], FILL};
   endfunction

   task automatic push_word(input logic [31:0] w, input logic last);
      int order[4] = '{3, 0, 1, 2};
      logic [7:0] b;
      for (int k = 0; k < 4; k++) begin
         b = 8'(w >> (8 * order[k]));
         exp_q.push_back({(last && (k == 3)), expand(b)});
      end
   endtask

   // output ready driver: 0 = always ready, 1 = pattern 1,0,0, 2 = random (mostly ready)
   initial begin
      o_tready = 1'b1;
      forever begin
         @(posedge clk);
         #1;
         case (rdy_mode)
            0: o_tready = 1'b1;
            1: begin
               o_tready = (pat == 0);
               pat = (pat + 1) % 3;
            end
            default: o_tready = ($urandom_range(0, 3) != 0);
         endcase
      end
   end

   // scoreboard: sampled on the falling edge, half a cycle before the transfer edge
   initial begin
      logic         stall_prev;
      logic [W-1:0] prev_out;
      stall_prev = 1'b0;
      prev_out   = '0;
      forever begin
         @(negedge clk);
         cyc++;
         if (reset) begin
            stall_prev = 1'b0;
         end else begin
            check("o_tvalid", W'(o_tvalid), W'(exp_q.size() != 0));
            check("i_tready", W'(i_tready),
                  W'((exp_q.size() == 0) || ((exp_q.size() == 1) && o_tready)));
            if (!o_tvalid) check("idle_out", {o_tlast, o_tdata}, '0);
            if (stall_prev) check("stall_hold", {o_tlast, o_tdata}, prev_out);
            if (o_tvalid && o_tready && (exp_q.size() != 0)) begin
               check("beat", {o_tlast, o_tdata}, exp_q.pop_front());
               obs_log.push_back(o_tdata);
               obs_last.push_back(o_tlast);
               beat_cyc.push_back(cyc);
            end
            if (i_tvalid && i_tready) push_word(i_tdata, i_tlast);
            stall_prev = o_tvalid & ~o_tready;
            prev_out   = {o_tlast, o_tdata};
         end
      end
   end

   // driver: present a word and hold it until accepted (bounded)
   task automatic send_word(input logic [31:0] d, input logic l);
      int n;
      i_tdata  = d;
      i_tlast  = l;
      i_tvalid = 1'b1;
      n = 0;
      @(negedge clk);
      while (!i_tready && (n < 200)) begin
         @(negedge clk);
         n++;
      end
      check("send_accepted", W'(i_tready), W'(1'b1));
      @(posedge clk);
      #1;
   endtask

   task automatic wait_beats(input int target);
      int n;
      n = 0;
      while ((obs_log.size() < target) && (n < 400)) begin
         @(negedge clk);
         n++;
      end
      check("beat_count", W'(obs_log.size() >= target), W'(1'b1));
      @(posedge clk);
      #1;
   endtask

   initial begin
      int base;
      logic [31:0] ka_single[4];
      logic [31:0] ka_bp[4];
      logic [31:0] ka_ff;
      logic [31:0] rw;
`ifdef UNZIP_MIDRISE_EN
      ka_single = '{32'hA8001800, 32'hD8004800, 32'hC8003800, 32'hB8002800};
      ka_bp     = '{32'h18002800, 32'h78008800, 32'h58006800, 32'h38004800};
      ka_ff     = 32'hF800F800;
`else
      ka_single = '{32'hA0001000, 32'hD0004000, 32'hC0003000, 32'hB0002000};
      ka_bp     = '{32'h10002000, 32'h70008000, 32'h50006000, 32'h30004000};
      ka_ff     = 32'hF000F000;
`endif

      // reset state
      reset    = 1'b1;
      i_tdata  = '0;
      i_tlast  = 1'b0;
      i_tvalid = 1'b0;
      #3;
      check("rst_o_tvalid", W'(o_tvalid), W'(1'b0));
      check("rst_o_tdata",  W'(o_tdata),  W'(32'h0));
      check("rst_o_tlast",  W'(o_tlast),  W'(1'b0));
      check("rst_i_tready", W'(i_tready), W'(1'b1));
      @(posedge clk);
      @(posedge clk);
      #1;
      reset = 1'b0;

      // single word
      base = obs_log.size();
      send_word(32'hA1B2C3D4, 1'b0);
      i_tvalid = 1'b0;
      wait_beats(base + 4);
      for (int k = 0; k < 4; k++) begin
         check("single_data", W'(obs_log[base+k]), W'(ka_single[k]));
         check("single_last", W'(obs_last[base+k]), W'(1'b0));
      end
      @(negedge clk);
      check("single_empty", W'(o_tvalid), W'(1'b0));

      // empty idle
      for (int k = 0; k < 20; k++) begin
         @(negedge clk);
         check("idle_tvalid", W'(o_tvalid), W'(1'b0));
         check("idle_tdata",  W'(o_tdata),  W'(32'h0));
         check("idle_tready", W'(i_tready), W'(1'b1));
      end
      @(posedge clk);
      #1;

      // streaming three words back to back
      base = obs_log.size();
      send_word(32'h01234567, 1'b0);
      send_word(32'h89ABCDEF, 1'b0);
      send_word(32'h7E57C0DE, 1'b1);
      i_tvalid = 1'b0;
      wait_beats(base + 12);
      for (int k = 1; k < 12; k++) begin
         check("stream_no_gap", W'(beat_cyc[base+k] - beat_cyc[base]), W'(k));
      end
      check("stream_last_11", W'(obs_last[base+10]), W'(1'b0));
      check("stream_last_12", W'(obs_last[base+11]), W'(1'b1));

      // backpressure
      rdy_mode = 1;
      base = obs_log.size();
      send_word(32'h12345678, 1'b0);
      i_tvalid = 1'b0;
      wait_beats(base + 4);
      for (int k = 0; k < 4; k++) begin
         check("bp_data", W'(obs_log[base+k]), W'(ka_bp[k]));
      end
      rdy_mode = 0;
      repeat (3) @(posedge clk);
      #1;

      // reset after the lane1 handshake
      base = obs_log.size();
      send_word(32'hC3C35A5A, 1'b1);
      i_tvalid = 1'b0;
      wait_beats(base + 2);
      #1;
      reset = 1'b1;
      exp_q.delete();
      #1;
      check("midrst_o_tvalid", W'(o_tvalid), W'(1'b0));
      check("midrst_o_tdata",  W'(o_tdata),  W'(32'h0));
      check("midrst_o_tlast",  W'(o_tlast),  W'(1'b0));
      @(posedge clk);
      @(posedge clk);
      #1;
      reset = 1'b0;
      base = obs_log.size();
      send_word(32'hFFFFFFFF, 1'b0);
      i_tvalid = 1'b0;
      wait_beats(base + 4);
      for (int k = 0; k < 4; k++) begin
         check("post_rst_data", W'(obs_log[base+k]), W'(ka_ff));
      end

      // random traffic
      for (int w = 0; w < 40; w++) begin
         rdy_mode = $urandom_range(0, 2);
         i_tvalid = 1'b0;
         repeat ($urandom_range(0, 2)) begin
            @(posedge clk);
            #1;
         end
         rw = $urandom();
         send_word(rw, ($urandom_range(0, 3) == 0));
      end
      i_tvalid = 1'b0;
      rdy_mode = 0;
      for (int n = 0; (n < 500) && (exp_q.size() != 0); n++) @(posedge clk);
      #1;
      check("drained", W'(exp_q.size()), W'(0));
      repeat (2) @(posedge clk);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
